// File: rtl/cr_prefix_fe_multi_pkg.sv
// rtl/cr_prefix_fe_multi_pkg.sv - shared types and helpers for the prefix feature-extraction engine
package cr_prefix_fe_multi_pkg;

  localparam int MAX_LANES = 64;

  typedef struct packed {
    logic       en;
    logic [7:0] lo;
    logic [7:0] hi;
  } fe_cfg_t;

  typedef enum logic {
    IDLE,
    XFER
  } snap_state_e;

  // An inverted range (lo > hi) can never satisfy both bounds, so it never hits.
  function automatic logic lane_hit(input fe_cfg_t cfg, input logic [7:0] b);
    return cfg.en && (b >= cfg.lo) && (b <= cfg.hi);
  endfunction

  function automatic logic [7:0] popcount_hits(input logic [MAX_LANES-1:0] hits);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) n = n + 8'(hits[i]);
    return n;
  endfunction

endpackage

// File: rtl/cr_prefix_fe_bank_ctr.sv
// rtl/cr_prefix_fe_bank_ctr.sv - one feature across all banks: lane match, popcount, saturating counters
module cr_prefix_fe_bank_ctr
  import cr_prefix_fe_multi_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int N_BANK = 4,
  parameter int CTR_W  = 8,
  parameter int BANK_W = 2,
  localparam int NBYTES = DWIDTH / 8,
  localparam int INC_W  = $clog2(NBYTES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          reload,
  input  fe_cfg_t                       cfg [N_BANK],
  input  logic [DWIDTH-1:0]             in_data,
  input  logic [NBYTES-1:0]             lane_mask,
  input  logic [BANK_W-1:0]             in_bank,
  input  logic                          s1_valid,
  input  logic [BANK_W-1:0]             s1_bank,
  output logic [N_BANK-1:0][CTR_W-1:0]  ctr,
  output logic [N_BANK-1:0]             sat
);

  fe_cfg_t                     sel_cfg;
  logic [NBYTES-1:0]           hits;
  logic [INC_W-1:0]            inc_d;
  logic [INC_W-1:0]            inc;
  logic [N_BANK-1:0][CTR_W:0]  sum;

  always_comb begin
    sel_cfg = '0;
    for (int k = 0; k < N_BANK; k++)
      if (in_bank == BANK_W'(k)) sel_cfg = cfg[k];
    hits = '0;
    for (int b = 0; b < NBYTES; b++)
      hits[b] = lane_mask[b] && lane_hit(sel_cfg, in_data[8*b +: 8]);
    inc_d = INC_W'(popcount_hits(MAX_LANES'(hits)));
  end

  // One spare bit catches overflow; a counter at max with inc = 0 stays below it.
  always_comb begin
    for (int k = 0; k < N_BANK; k++)
      sum[k] = {1'b0, ctr[k]} + (CTR_W + 1)'(inc);
  end

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      inc <= '0;
      ctr <= '0;
      sat <= '0;
    end else begin
      inc <= inc_d;
      if (s1_valid) begin
        for (int k = 0; k < N_BANK; k++) begin
          if (s1_bank == BANK_W'(k)) begin
            if (sum[k][CTR_W]) begin
              ctr[k] <= '1;
              sat[k] <= 1'b1;
            end else begin
              ctr[k] <= sum[k][CTR_W-1:0];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/cr_prefix_fe_multi.sv
// rtl/cr_prefix_fe_multi.sv - banked byte-range feature counters with snapshot readout stream
module cr_prefix_fe_multi
  import cr_prefix_fe_multi_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int N_FEAT = 64,
  parameter int N_BANK = 4,
  parameter int CTR_W  = 8,
  localparam int NBYTES = DWIDTH / 8,
  localparam int VB_W   = $clog2(NBYTES + 1),
  localparam int BANK_W = (N_BANK > 1) ? $clog2(N_BANK) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  fe_cfg_t                         fe_config [N_BANK*N_FEAT],
  input  logic                            in_valid,
  input  logic [DWIDTH-1:0]               in_data,
  input  logic [VB_W-1:0]                 in_vbytes,
  input  logic [BANK_W-1:0]               in_blk_sel,
  input  logic                            ctr_reload,
  output logic [N_BANK*N_FEAT*CTR_W-1:0]  feature_ctr,
  input  logic                            snap_req,
  output logic                            snap_busy,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [BANK_W-1:0]               rd_bank,
  output logic [N_FEAT*CTR_W-1:0]         rd_data,
  output logic [N_FEAT-1:0]               rd_sat,
  output logic                            rd_last
);

  logic [NBYTES-1:0]                     lane_mask;
  logic                                  s1_valid;
  logic [BANK_W-1:0]                     s1_bank;
  logic [N_BANK-1:0][N_FEAT*CTR_W-1:0]   bank_ctr;
  logic [N_BANK-1:0][N_FEAT-1:0]         bank_sat;
  logic [N_BANK-1:0][N_FEAT*CTR_W-1:0]   shadow_ctr;
  logic [N_BANK-1:0][N_FEAT-1:0]         shadow_sat;
  snap_state_e                           state_q, state_d;
  logic                                  at_last;

  // Comparing against the raw count clamps oversize in_vbytes to all lanes.
  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < NBYTES; b++) lane_mask[b] = (int'(in_vbytes) > b);
  end

  always_ff @(posedge clk) begin
    if (rst || ctr_reload) begin
      s1_valid <= 1'b0;
      s1_bank  <= '0;
    end else begin
      s1_valid <= in_valid && (in_vbytes != '0);
      s1_bank  <= in_blk_sel;
    end
  end

  for (genvar f = 0; f < N_FEAT; f++) begin : g_feat
    fe_cfg_t                     fcfg [N_BANK];
    logic [N_BANK-1:0][CTR_W-1:0] fctr;
    logic [N_BANK-1:0]            fsat;

    for (genvar k = 0; k < N_BANK; k++) begin : g_bank
      assign fcfg[k]                       = fe_config[k*N_FEAT+f];
      assign bank_ctr[k][f*CTR_W +: CTR_W] = fctr[k];
      assign bank_sat[k][f]                = fsat[k];
    end

    cr_prefix_fe_bank_ctr #(
      .DWIDTH (DWIDTH),
      .N_BANK (N_BANK),
      .CTR_W  (CTR_W),
      .BANK_W (BANK_W)
    ) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .reload    (ctr_reload),
      .cfg       (fcfg),
      .in_data   (in_data),
      .lane_mask (lane_mask),
      .in_bank   (in_blk_sel),
      .s1_valid  (s1_valid),
      .s1_bank   (s1_bank),
      .ctr       (fctr),
      .sat       (fsat)
    );
  end

  assign feature_ctr = bank_ctr;

  always_comb begin
    state_d   = state_q;
    snap_busy = (state_q == XFER);
    rd_valid  = (state_q == XFER);
    at_last   = (rd_bank == BANK_W'(N_BANK - 1));
    rd_last   = rd_valid && at_last;
    case (state_q)
      IDLE:    if (snap_req) state_d = XFER;
      XFER:    if (rd_ready && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shadow samples the counters as they stand before this edge, so a
  // same-edge S2 update or reload is not part of the snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_bank    <= '0;
      shadow_ctr <= '0;
      shadow_sat <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && snap_req) begin
        shadow_ctr <= bank_ctr;
        shadow_sat <= bank_sat;
        rd_bank    <= '0;
      end else if (state_q == XFER && rd_ready) begin
        rd_bank <= at_last ? '0 : rd_bank + 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_sat  = '0;
    for (int k = 0; k < N_BANK; k++) begin
      if (rd_bank == BANK_W'(k)) begin
        rd_data = shadow_ctr[k];
        rd_sat  = shadow_sat[k];
      end
    end
  end

endmodule

// File: tb/tb_cr_prefix_fe_multi.sv
// tb/tb_cr_prefix_fe_multi.sv - directed bench with snapshot scoreboard for cr_prefix_fe_multi
module tb_cr_prefix_fe_multi;
  import cr_prefix_fe_multi_pkg::*;

  localparam int DWIDTH = 64;
  localparam int N_FEAT = 64;
  localparam int N_BANK = 4;
  localparam int CTR_W  = 8;
  localparam int NBYTES = DWIDTH / 8;
  localparam int VB_W   = $clog2(NBYTES + 1);
  localparam int BANK_W = 2;
  localparam logic [DWIDTH-1:0] ALL_A = 64'h4141_4141_4141_4141;

  logic                            clk = 1'b0;
  logic                            rst;
  fe_cfg_t                         fe_config [N_BANK*N_FEAT];
  logic                            in_valid;
  logic [DWIDTH-1:0]               in_data;
  logic [VB_W-1:0]                 in_vbytes;
  logic [BANK_W-1:0]               in_blk_sel;
  logic                            ctr_reload;
  logic [N_BANK*N_FEAT*CTR_W-1:0]  feature_ctr;
  logic                            snap_req;
  logic                            snap_busy;
  logic                            rd_valid;
  logic                            rd_ready;
  logic [BANK_W-1:0]               rd_bank;
  logic [N_FEAT*CTR_W-1:0]         rd_data;
  logic [N_FEAT-1:0]               rd_sat;
  logic                            rd_last;

  typedef struct {
    logic [BANK_W-1:0] bank;
    logic [7:0]        d;
    logic              s;
    logic              last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  cr_prefix_fe_multi #(
    .DWIDTH (DWIDTH),
    .N_FEAT (N_FEAT),
    .N_BANK (N_BANK),
    .CTR_W  (CTR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fe_config   (fe_config),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_vbytes   (in_vbytes),
    .in_blk_sel  (in_blk_sel),
    .ctr_reload  (ctr_reload),
    .feature_ctr (feature_ctr),
    .snap_req    (snap_req),
    .snap_busy   (snap_busy),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_bank     (rd_bank),
    .rd_data     (rd_data),
    .rd_sat      (rd_sat),
    .rd_last     (rd_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [CTR_W-1:0] ctr_of(input int b, input int f);
    return feature_ctr[(b*N_FEAT+f)*CTR_W +: CTR_W];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic beat(input logic [DWIDTH-1:0] d, input int vb, input int bank);
    in_valid   = 1'b1;
    in_data    = d;
    in_vbytes  = VB_W'(vb);
    in_blk_sel = BANK_W'(bank);
    step();
    in_valid   = 1'b0;
  endtask

  task automatic push_snap(input logic [31:0] dv, input logic [3:0] sv);
    for (int k = 0; k < N_BANK; k++) begin
      exp_t e;
      e.bank = BANK_W'(k);
      e.d    = dv[8*k +: 8];
      e.s    = sv[k];
      e.last = (k == N_BANK - 1);
      sb.push_back(e);
    end
  endtask

  task automatic run_snap(input int stall, input bit extra_req);
    exp_t e;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("snap_busy_set", snap_busy, 1);
    for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
      rd_ready = (cyc >= stall);
      snap_req = extra_req && (cyc == 1);
      if (!rd_valid) begin
        chk("rd_valid_dropped", rd_valid, 1);
        break;
      end
      e = sb[0];
      chk("rd_bank", rd_bank, e.bank);
      chk("rd_data_f0", rd_data[CTR_W-1:0], e.d);
      chk("rd_sat_f0", rd_sat[0], e.s);
      chk("rd_last", rd_last, e.last);
      if (rd_ready) void'(sb.pop_front());
      step();
    end
    rd_ready = 1'b0;
    snap_req = 1'b0;
    chk("snap_beats_left", sb.size(), 0);
    sb.delete();
    chk("rd_valid_end", rd_valid, 0);
    chk("snap_busy_end", snap_busy, 0);
    step();
    chk("snap_busy_idle", snap_busy, 0);
  endtask

  initial begin
    for (int i = 0; i < N_BANK*N_FEAT; i++) fe_config[i] = '{en: 1'b0, lo: 8'h00, hi: 8'h00};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_vbytes = '0; in_blk_sel = '0;
    ctr_reload = 1'b0; snap_req = 1'b0; rd_ready = 1'b0;
    step(); step();
    chk("reset_ctr", |feature_ctr, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_busy", snap_busy, 0);
    chk("reset_rd_bank", rd_bank, 0);
    chk("reset_rd_last", rd_last, 0);
    rst = 1'b0;
    step();

    // T1: basic count, bank isolation, second feature, inverted range
    fe_config[0]        = '{en: 1'b1, lo: 8'h41, hi: 8'h41};
    fe_config[N_FEAT]   = '{en: 1'b1, lo: 8'h41, hi: 8'h41};
    fe_config[1]        = '{en: 1'b1, lo: 8'h42, hi: 8'h43};
    fe_config[2]        = '{en: 1'b1, lo: 8'h43, hi: 8'h41};
    beat(64'h4100_4100_4142_4300, 8, 0);
    chk("t1_latency", ctr_of(0, 0), 0);
    step();
    chk("t1_b0f0", ctr_of(0, 0), 3);
    chk("t1_b1f0", ctr_of(1, 0), 0);
    chk("t1_b0f1", ctr_of(0, 1), 2);
    chk("t1_b0f2_inv", ctr_of(0, 2), 0);

    // T2: valid-byte handling
    beat(ALL_A, 5, 0); step();
    chk("t2_vb5", ctr_of(0, 0), 8);
    chk("t2_vb5_f1", ctr_of(0, 1), 2);
    beat(ALL_A, 0, 0); step();
    chk("t2_vb0", ctr_of(0, 0), 8);
    beat(ALL_A, 15, 0); step();
    chk("t2_vb15", ctr_of(0, 0), 16);

    // T3: saturation with sticky flag
    ctr_reload = 1'b1; step(); ctr_reload = 1'b0;
    chk("t3_reload", ctr_of(0, 0), 0);
    in_valid = 1'b1; in_data = ALL_A; in_vbytes = VB_W'(8); in_blk_sel = '0;
    for (int i = 0; i < 33; i++) step();
    in_valid = 1'b0;
    step(); step();
    chk("t3_sat_ctr", ctr_of(0, 0), 255);
    push_snap({8'd0, 8'd0, 8'd0, 8'd255}, 4'b0001);
    run_snap(0, 1'b0);

    // T4: reload squashes in-flight and same-cycle beats
    beat(ALL_A, 8, 0);
    ctr_reload = 1'b1;
    beat(ALL_A, 8, 0);
    ctr_reload = 1'b0;
    chk("t4_after_t", ctr_of(0, 0), 0);
    beat(ALL_A, 3, 0);
    chk("t4_after_t1", ctr_of(0, 0), 0);
    step();
    chk("t4_after_t2", ctr_of(0, 0), 3);

    // T5: snapshot with stall and ignored mid-transfer request
    ctr_reload = 1'b1; step(); ctr_reload = 1'b0;
    fe_config[2*N_FEAT] = '{en: 1'b1, lo: 8'h41, hi: 8'h41};
    fe_config[3*N_FEAT] = '{en: 1'b1, lo: 8'h41, hi: 8'h41};
    for (int k = 0; k < N_BANK; k++) beat(ALL_A, k + 1, k);
    step(); step();
    for (int k = 0; k < N_BANK; k++) chk("t5_ctr", ctr_of(k, 0), k + 1);
    push_snap({8'd4, 8'd3, 8'd2, 8'd1}, 4'b0000);
    run_snap(3, 1'b1);

    // T6: snapshot taken with a same-cycle reload, then rst mid-transfer
    snap_req = 1'b1; ctr_reload = 1'b1;
    step();
    snap_req = 1'b0; ctr_reload = 1'b0;
    chk("t6_reload_ctr", ctr_of(3, 0), 0);
    chk("t6_busy", snap_busy, 1);
    chk("t6_bank0", rd_bank, 0);
    chk("t6_pre_reload_data", rd_data[CTR_W-1:0], 1);
    rd_ready = 1'b1;
    beat(ALL_A, 8, 0);
    rd_ready = 1'b0;
    chk("t6_bank1", rd_bank, 1);
    chk("t6_data1", rd_data[CTR_W-1:0], 2);
    step();
    chk("t6_count_in_xfer", ctr_of(0, 0), 8);
    chk("t6_stalled_bank", rd_bank, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_busy_clr", snap_busy, 0);
    chk("t6_rd_bank", rd_bank, 0);
    chk("t6_rd_last", rd_last, 0);
    chk("t6_ctr_zero", |feature_ctr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
